// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states and
// the width of the wait-state counter.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data, load lane
// select with zero/sign extension, and a misalignment indication.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be       = '0;
        o_wword    = '0;
        o_rdata    = '0;
        o_misalign = 1'b0;
        w_byte     = i_rword[{i_addr_lo, 3'b000} +: 8];
        w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                // Half accesses use addr[1] only; addr[0] just flags misalignment.
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword    = {2{i_wdata[15:0]}};
                o_rdata    = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_be       = 4'b1111;
                o_wword    = i_wdata;
                o_rdata    = i_rword;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Word-organised data memory with byte/half/word access, valid/ready request
// port and fixed wait-state latency. DMEM_MISALIGN_TRAP_EN makes misaligned
// half/word accesses an error instead of accessing the aligned location.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e                r_state, w_state_nxt;
    logic [WAIT_W-1:0]     r_cnt;
    logic                  r_write, r_unsigned;
    size_e                 r_size;
    logic [31:0]           r_addr, r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_commit, w_oor, w_misalign, w_err;
    logic [3:0]            w_be;
    logic [31:0]           w_wword, w_load;

    assign w_idx    = r_addr[DEPTH_LOG2+1:2];
    assign w_oor    = (r_addr >> (DEPTH_LOG2 + 2)) != '0;
    assign w_err    = w_oor || (r_size == SZ_RSVD) || (w_misalign && TRAP_EN);
    assign w_commit = (r_state == ST_BUSY) && (r_cnt == '0);

    dmem_lane_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_load),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)   w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && req_valid) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= size_e'(req_size);
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_cnt      <= WAIT_W'(WAIT_STATES);
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? '0 : w_load;
            end
        end
    end

    // Array is not reset; an async reset drops r_state to IDLE so a pending store never commits.
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit (DEPTH_LOG2=8, WAIT_STATES=1).
module tb_data_memory_unit;

    localparam int unsigned WS = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    data_memory_unit #(.DEPTH_LOG2(8), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int lat;
        logic low;
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        low = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_ready) low = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(WS + 2));
        check({tag, ".ready_low"}, 32'(low), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, ".hold"}, rsp_rdata, rd);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] rd;
        logic er;
        access(tag, 1'b0, sz, uns, addr, '0, rd, er);
        check({tag, ".rdata"}, rd, exp_d);
        check({tag, ".err"}, 32'(er), 32'(exp_e));
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic exp_e);
        logic [31:0] rd;
        logic er;
        access(tag, 1'b1, sz, 1'b0, addr, wd, rd, er);
        check({tag, ".rdata"}, rd, 32'h0);
        check({tag, ".err"}, 32'(er), 32'(exp_e));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        st("sw10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lw10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

        st("sw20", 2'b10, 32'h20, 32'h11223344, 1'b0);
        st("sb21", 2'b00, 32'h21, 32'h0000007F, 1'b0);
        ld("lw20", 2'b10, 1'b0, 32'h20, 32'h11227F44, 1'b0);
        ld("lb21", 2'b00, 1'b0, 32'h21, 32'h0000007F, 1'b0);
        st("sb22", 2'b00, 32'h22, 32'h00000080, 1'b0);
        ld("lb22", 2'b00, 1'b0, 32'h22, 32'hFFFFFF80, 1'b0);
        ld("lbu22", 2'b00, 1'b1, 32'h22, 32'h00000080, 1'b0);
        ld("lw20b", 2'b10, 1'b1, 32'h20, 32'h11807F44, 1'b0);

        st("sh32", 2'b01, 32'h32, 32'h0000BEEF, 1'b0);
        ld("lh32", 2'b01, 1'b0, 32'h32, 32'hFFFFBEEF, 1'b0);
        ld("lhu32", 2'b01, 1'b1, 32'h32, 32'h0000BEEF, 1'b0);

        st("sw00", 2'b10, 32'h0, 32'h01020304, 1'b0);
        ld("lw400", 2'b10, 1'b0, 32'h400, 32'h0, 1'b1);
        ld("lrsvd", 2'b11, 1'b0, 32'h10, 32'h0, 1'b1);
        st("sw400", 2'b10, 32'h400, 32'hCAFEF00D, 1'b1);
        st("srsvd", 2'b11, 32'h10, 32'h55555555, 1'b1);
        ld("lw00_keep", 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0);
        ld("lw10_keep", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        ld("lw13", 2'b10, 1'b0, 32'h13, 32'h0, 1'b1);
        st("sh33", 2'b01, 32'h33, 32'h00001234, 1'b1);
        ld("lw30_keep", 2'b10, 1'b0, 32'h30, {16'hBEEF, 16'hxxxx}, 1'b0);
        ld("lw10_mis", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
`else
        ld("lw13", 2'b10, 1'b0, 32'h13, 32'hDEADBEEF, 1'b0);
        ld("lh33", 2'b01, 1'b0, 32'h33, 32'hFFFFBEEF, 1'b0);
`endif

        st("sw40", 2'b10, 32'h40, 32'h00000005, 1'b0);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.valid", 32'(rsp_valid), 32'd0);
        check("abort.ready", 32'(req_ready), 32'd1);
        check("abort.rdata", rsp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.valid_after", 32'(rsp_valid), 32'd0);
        check("abort.ready_after", 32'(req_ready), 32'd1);
        ld("lw40", 2'b10, 1'b0, 32'h40, 32'h00000005, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
